// File: rtl/sram_1rw1r_wmask_pkg.sv
// Shared helpers for the 1RW+1R masked SRAM model: lane width and parameter sanity checks.
package sram_pkg;

  // Bits per write-mask lane.
  function automatic int unsigned lane_w(input int unsigned data_w, input int unsigned mask_w);
    return data_w / mask_w;
  endfunction

  // Data width must split evenly into mask lanes.
  function automatic bit lanes_ok(input int unsigned data_w, input int unsigned mask_w);
    return (mask_w != 0) && ((data_w % mask_w) == 0);
  endfunction

  // Implemented depth must fit in the address space.
  function automatic bit depth_ok(input int unsigned words, input int unsigned addr_w);
    return 64'(words) <= (64'd1 << addr_w);
  endfunction

endpackage

// File: rtl/sram_1rw1r_wmask_port_reg.sv
// Posedge input register for one SRAM port; reset forces the port deselected.
module sram_port_reg
  import sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WMASK_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   csb,
  input  logic                   web,
  input  logic [WMASK_WIDTH-1:0] wmask,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]  din,
  output logic                   csb_r,
  output logic                   web_r,
  output logic [WMASK_WIDTH-1:0] wmask_r,
  output logic [ADDR_WIDTH-1:0]  addr_r,
  output logic [DATA_WIDTH-1:0]  din_r,
  output logic                   rst_r
);

  // Capture the request; reset cancels it by deselecting the port.
  always_ff @(posedge clk) begin
    wmask_r <= wmask;
    addr_r  <= addr;
    din_r   <= din;
    if (rst) begin
      csb_r <= 1'b1;
      web_r <= 1'b1;
      rst_r <= 1'b1;
    end else begin
      csb_r <= csb;
      web_r <= web;
      rst_r <= 1'b0;
    end
  end

endmodule

// File: rtl/sram_1rw1r_wmask.sv
// Behavioural 1RW + 1R SRAM with per-lane write mask, read-valid flags and collision flag.
module sram_1rw1r_wmask
  import sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WMASK_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned NUM_WORDS   = 256,
  parameter bit          VERBOSE     = 1'b1
) (
  input  logic                   clk0,
  input  logic                   rst0,
  input  logic                   csb0,
  input  logic                   web0,
  input  logic [WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0]  din0,
  output logic [DATA_WIDTH-1:0]  dout0,
  output logic                   dout0_vld,
  input  logic                   csb1,
  input  logic [ADDR_WIDTH-1:0]  addr1,
  output logic [DATA_WIDTH-1:0]  dout1,
  output logic                   dout1_vld,
  output logic                   coll1
);

  localparam int unsigned LW = lane_w(DATA_WIDTH, WMASK_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(NUM_WORDS);

  // Reject inconsistent parameter sets at elaboration.
  if (!lanes_ok(DATA_WIDTH, WMASK_WIDTH)) begin : g_bad_lanes
    $fatal(1, "sram_1rw1r_wmask: DATA_WIDTH must be a multiple of WMASK_WIDTH");
  end
  if (!depth_ok(NUM_WORDS, ADDR_WIDTH)) begin : g_bad_depth
    $fatal(1, "sram_1rw1r_wmask: NUM_WORDS exceeds 2**ADDR_WIDTH");
  end

  logic                   csb0_r, web0_r, rst_r;
  logic [WMASK_WIDTH-1:0] wmask0_r;
  logic [ADDR_WIDTH-1:0]  addr0_r;
  logic [DATA_WIDTH-1:0]  din0_r;

  logic                   csb1_r, web1_r, rst1_r;
  logic [WMASK_WIDTH-1:0] wmask1_r;
  logic [ADDR_WIDTH-1:0]  addr1_r;
  logic [DATA_WIDTH-1:0]  din1_r;

  logic [DATA_WIDTH-1:0]  mem [NUM_WORDS];

  sram_port_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .WMASK_WIDTH(WMASK_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_port0 (
    .clk    (clk0),
    .rst    (rst0),
    .csb    (csb0),
    .web    (web0),
    .wmask  (wmask0),
    .addr   (addr0),
    .din    (din0),
    .csb_r  (csb0_r),
    .web_r  (web0_r),
    .wmask_r(wmask0_r),
    .addr_r (addr0_r),
    .din_r  (din0_r),
    .rst_r  (rst_r)
  );

  // Port 1 is read-only: write controls are tied inactive.
  sram_port_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .WMASK_WIDTH(WMASK_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_port1 (
    .clk    (clk0),
    .rst    (rst0),
    .csb    (csb1),
    .web    (1'b1),
    .wmask  ('0),
    .addr   (addr1),
    .din    ('0),
    .csb_r  (csb1_r),
    .web_r  (web1_r),
    .wmask_r(wmask1_r),
    .addr_r (addr1_r),
    .din_r  (din1_r),
    .rst_r  (rst1_r)
  );

  // Tied-off port 1 write path and duplicate reset copy carry no information.
  logic unused_p1;
  assign unused_p1 = ^{web1_r, wmask1_r, din1_r, rst1_r};

  logic rd0_c, wr0_c, rd1_c, in0_c, in1_c;
  assign rd0_c = !csb0_r && web0_r;
  assign wr0_c = !csb0_r && !web0_r;
  assign rd1_c = !csb1_r;
  assign in0_c = {1'b0, addr0_r} < DEPTH;
  assign in1_c = {1'b0, addr1_r} < DEPTH;

  // Array stage: reads sample the array before the write lands (read-before-write).
  always_ff @(negedge clk0) begin
    if (rst_r) begin
      dout0     <= '0;
      dout1     <= '0;
      dout0_vld <= 1'b0;
      dout1_vld <= 1'b0;
      coll1     <= 1'b0;
    end else begin
      dout0_vld <= rd0_c;
      if (rd0_c) begin
        if (in0_c) begin
          dout0 <= mem[addr0_r];
          if (VERBOSE) $display("sram: port0 read  addr=%0d data=%h", addr0_r, mem[addr0_r]);
        end else begin
          dout0 <= '0;
          $display("sram warning: port0 read out of range addr=%0d", addr0_r);
        end
      end

      dout1_vld <= rd1_c;
      if (rd1_c) begin
        if (in1_c) begin
          dout1 <= mem[addr1_r];
          if (VERBOSE) $display("sram: port1 read  addr=%0d data=%h", addr1_r, mem[addr1_r]);
        end else begin
          dout1 <= '0;
          $display("sram warning: port1 read out of range addr=%0d", addr1_r);
        end
      end

      if (wr0_c) begin
        if (in0_c) begin
          for (int i = 0; i < int'(WMASK_WIDTH); i++) begin
            if (wmask0_r[i]) mem[addr0_r][i*LW +: LW] <= din0_r[i*LW +: LW];
          end
          if (VERBOSE) $display("sram: port0 write addr=%0d data=%h mask=%b", addr0_r, din0_r, wmask0_r);
        end else begin
          $display("sram warning: port0 write out of range addr=%0d dropped", addr0_r);
        end
      end

      coll1 <= rd1_c && wr0_c && (addr1_r == addr0_r);
    end
  end

endmodule
